// File: rtl/n64_pif_si_dma.sv
// rtl/n64_pif_si_dma.sv - SI-side word transfer engine driving PIF RAM port B.
// Moves 1..16 word blocks between a word stream and the RAM, raising pif_irq when a write block lands.
module n64_pif_si_dma #(
   parameter int RAM_AW = 9,
   parameter int LEN_W  = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_dir_i,
   input  logic [RAM_AW-1:0] cmd_addr_i,
   input  logic [LEN_W-1:0]  cmd_len_i,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   input  logic [31:0]       wr_data_i,
   output logic              rd_valid_o,
   input  logic              rd_ready_i,
   output logic [31:0]       rd_data_o,
   output logic [RAM_AW-1:0] ram_address_o,
   output logic              ram_wren_o,
   output logic [31:0]       ram_data_o,
   input  logic [31:0]       ram_q_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pif_irq_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_RD_ADDR,
      S_RD_WAIT,
      S_RD_HOLD,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [RAM_AW-1:0]   ptr_q, ptr_d;
   logic [LEN_W-1:0]    count_q, count_d;
   logic                dir_q, dir_d;
   logic [31:0]         rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         count_q    <= '0;
         dir_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         count_q    <= count_d;
         dir_q      <= dir_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      dir_d      = dir_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               ptr_d   = cmd_addr_i;
               count_d = cmd_len_i;
               dir_d   = cmd_dir_i;
               state_d = cmd_dir_i ? S_RD_ADDR : S_WRITE;
            end
         end
         S_WRITE: begin
            if (wr_valid_i) begin
               if (count_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  ptr_d   = ptr_q + RAM_AW'(1);
                  count_d = count_q - LEN_W'(1);
               end
            end
         end
         S_RD_ADDR: state_d = S_RD_WAIT;
         // RAM output is registered: ram_q is valid one cycle after the address.
         S_RD_WAIT: begin
            rd_data_d  = ram_q_i;
            rd_valid_d = 1'b1;
            state_d    = S_RD_HOLD;
         end
         S_RD_HOLD: begin
            if (rd_ready_i) begin
               rd_valid_d = 1'b0;
               if (count_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  ptr_d   = ptr_q + RAM_AW'(1);
                  count_d = count_q - LEN_W'(1);
                  state_d = S_RD_ADDR;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ready_o   = (state_q == S_IDLE);
   assign wr_ready_o    = (state_q == S_WRITE);
   assign ram_wren_o    = wr_valid_i & wr_ready_o;
   assign ram_address_o = ptr_q;
   assign ram_data_o    = wr_data_i;
   assign rd_valid_o    = rd_valid_q;
   assign rd_data_o     = rd_data_q;
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_DONE);
   assign pif_irq_o     = done_o & ~dir_q;

endmodule

// File: tb/tb_n64_pif_si_dma.sv
// tb/tb_n64_pif_si_dma.sv - scoreboard bench for n64_pif_si_dma with a behavioural RAM.
module tb_n64_pif_si_dma;
   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_dir;
   logic [8:0]  cmd_addr;
   logic [3:0]  cmd_len;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid, rd_ready;
   logic [31:0] rd_data;
   logic [8:0]  ram_address;
   logic        ram_wren;
   logic [31:0] ram_data, ram_q;
   logic        busy, done, pif_irq;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_evt = 0;

   logic [31:0] ram     [0:511];
   logic [31:0] ref_mem [0:511];
   logic [8:0]  exp_wr_addr[$];
   logic [31:0] exp_wr_data[$];
   logic [31:0] exp_rd[$];
   logic        exp_done_dir[$];

   always #5 clk = ~clk;

   n64_pif_si_dma dut (
      .clk_i(clk), .reset_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_dir_i(cmd_dir),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
      .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
      .ram_address_o(ram_address), .ram_wren_o(ram_wren), .ram_data_o(ram_data),
      .ram_q_i(ram_q), .busy_o(busy), .done_o(done), .pif_irq_o(pif_irq)
   );

   // Single-port RAM with registered read data, as seen on PIF RAM port B.
   always @(posedge clk) begin
      if (ram_wren) ram[ram_address] <= ram_data;
      ram_q <= ram[ram_address];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes RAM, hands over a read word, or finishes.
   always @(negedge clk) begin
      if (ram_wren) begin
         chk("wren_expected", {31'b0, exp_wr_addr.size() > 0}, 32'd1);
         if (exp_wr_addr.size() > 0) begin
            chk("wr_addr", {23'b0, ram_address}, {23'b0, exp_wr_addr.pop_front()});
            chk("wr_data", ram_data, exp_wr_data.pop_front());
         end
         last_evt = cyc;
      end
      if (rd_valid && rd_ready) begin
         chk("rd_expected", {31'b0, exp_rd.size() > 0}, 32'd1);
         if (exp_rd.size() > 0) chk("rd_data", rd_data, exp_rd.pop_front());
         last_evt = cyc;
      end
      if (done) begin
         chk("done_expected", {31'b0, exp_done_dir.size() > 0}, 32'd1);
         if (exp_done_dir.size() > 0)
            chk("pif_irq_at_done", {31'b0, pif_irq}, {31'b0, ~exp_done_dir.pop_front()});
         chk("done_latency", cyc, last_evt + 1);
      end
      if (pif_irq && !done) chk("irq_without_done", 32'd1, 32'd0);
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic issue(input bit dir, input int addr, input int len);
      int n = 0;
      cmd_dir   = dir;
      cmd_addr  = 9'(addr);
      cmd_len   = 4'(len);
      cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_dir   = 1'($urandom);
      cmd_addr  = 9'($urandom);
      cmd_len   = 4'($urandom);
   endtask

   // mode 0: wr_valid held high, 1: toggling, 2: random. stop >= 0 feeds only that many words.
   task automatic do_write(input int addr, input int len, input int mode, input bit rnd,
                           input logic [31:0] base, input int stop);
      logic [31:0] d[$];
      logic [8:0]  a;
      int nacc, i, t;
      nacc = (stop >= 0) ? stop : len + 1;
      for (int k = 0; k <= len; k++) d.push_back(rnd ? $urandom : base + 32'(k));
      for (int k = 0; k < nacc; k++) begin
         a = 9'(addr + k);
         exp_wr_addr.push_back(a);
         exp_wr_data.push_back(d[k]);
         ref_mem[a] = d[k];
      end
      if (stop < 0) exp_done_dir.push_back(1'b0);
      issue(1'b0, addr, len);
      i = 0;
      t = 0;
      while (i < nacc && t < 500) begin
         wr_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
         wr_data  = d[i];
         @(negedge clk);
         if (wr_valid && wr_ready) i++;
         @(posedge clk); #1;
         t++;
      end
      chk("wr_words", i, nacc);
      if (mode == 0) chk("wr_back_to_back", t, nacc);
      if (stop < 0) begin
         wr_valid = 1'b0;
         wr_data  = $urandom;
         wait_idle();
      end
   endtask

   // mode 0: rd_ready always, 1: random, 2: first word held off for 10 cycles.
   task automatic do_read(input int addr, input int len, input int mode);
      logic [31:0] held_data;
      logic [8:0]  held_addr;
      int i, t, hold, prev;
      for (int k = 0; k <= len; k++) exp_rd.push_back(ref_mem[9'(addr + k)]);
      exp_done_dir.push_back(1'b1);
      issue(1'b1, addr, len);
      i = 0;
      t = 0;
      hold = 0;
      prev = 0;
      while (i <= len && t < 500) begin
         rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1))
                                      : !(i == 0 && hold < 10);
         @(negedge clk);
         if (mode == 2 && rd_valid && !rd_ready) begin
            if (hold == 0) begin
               held_data = rd_data;
               held_addr = ram_address;
            end else begin
               chk("bp_data_stable", rd_data, held_data);
               chk("bp_ptr_stable", {23'b0, ram_address}, {23'b0, held_addr});
            end
            hold++;
         end
         if (rd_valid && rd_ready) begin
            if (mode != 1 && i > 0) chk("rd_word_spacing", cyc - prev, 3);
            prev = cyc;
            i++;
         end
         @(posedge clk); #1;
         t++;
      end
      rd_ready = 1'b0;
      chk("rd_words", i, len + 1);
      if (mode == 2) chk("bp_hold_cycles", hold, 10);
      wait_idle();
   endtask

   initial begin
      for (int k = 0; k < 512; k++) begin
         ram[k]     = 32'h0;
         ref_mem[k] = 32'h0;
      end
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_ptr", {23'b0, ram_address}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      do_write(9'h1F0, 15, 0, 1'b0, 32'hA000_0000, -1);
      do_read(9'h1F0, 15, 0);
      do_read(9'h1F4, 1, 2);
      do_write(9'h1FE, 3, 1, 1'b1, 32'h0, -1);
      do_read(9'h1FE, 3, 0);
      do_write(9'h005, 0, 0, 1'b0, 32'h1234_5678, -1);
      do_read(9'h005, 0, 0);

      // Abandon a write after 3 of 8 words; wr_valid stays high through reset.
      do_write(9'h040, 7, 0, 1'b1, 32'h0, 3);
      rst = 1'b1;
      cmd_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_wren", {31'b0, ram_wren}, 32'd0);
         chk("mid_rst_busy", {31'b0, busy}, 32'd0);
         chk("mid_rst_done", {31'b0, done}, 32'd0);
         chk("mid_rst_rd_data", rd_data, 32'd0);
      end
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      wr_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("post_rst_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      do_read(9'h040, 7, 1);

      for (int r = 0; r < 20; r++) begin
         if ($urandom_range(0, 1) == 0)
            do_write(int'($urandom_range(0, 511)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 2)), 1'b1, 32'h0, -1);
         else
            do_read(int'($urandom_range(0, 511)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)));
      end

      repeat (3) @(negedge clk);
      chk("sb_wr_empty", exp_wr_addr.size(), 0);
      chk("sb_rd_empty", exp_rd.size(), 0);
      chk("sb_done_empty", exp_done_dir.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
